// File: rtl/switch_pkg.sv
// Shared types and constants for the switch-driven up/down counter.
// Optional build macro AUTO_REPEAT_EN enables the hold-to-repeat FSM in the top.
package switch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } rpt_state_t;

   localparam int COUNT_W     = 4;
   localparam int SYNC_STAGES = 2;

   // Counter width able to hold limit-1; never narrower than one bit.
   function automatic int cnt_width(input int limit);
      return (limit > 1) ? $clog2(limit) : 1;
   endfunction

endpackage

// File: rtl/switch_updown_counter_if.sv
// Pin-side bundle of the counter: raw switches in, LEDs, step pulse and repeat-state debug out.
// The repeat state reads ST_IDLE permanently when AUTO_REPEAT_EN is not defined.
interface switch_updown_counter_if;
   import switch_pkg::*;

   logic       i_Switch_1;
   logic       i_Switch_2;
   logic       i_Switch_3;
   logic       o_LED_1;
   logic       o_LED_2;
   logic       o_LED_3;
   logic       o_LED_4;
   logic       o_Step;
   rpt_state_t o_Rpt_State;

   // Board/bench side drives the switches and watches the outputs.
   modport master (
      output i_Switch_1, i_Switch_2, i_Switch_3,
      input  o_LED_1, o_LED_2, o_LED_3, o_LED_4, o_Step, o_Rpt_State
   );

   modport slave (
      input  i_Switch_1, i_Switch_2, i_Switch_3,
      output o_LED_1, o_LED_2, o_LED_3, o_LED_4, o_Step, o_Rpt_State
   );

endinterface

// File: rtl/switch_debounce.sv
// One switch channel: 2-FF synchroniser, stability filter and a registered press pulse.
// o_Level is the debounced level; o_Press is high for one cycle after each clean 0->1.
module switch_debounce
   import switch_pkg::*;
#(
   parameter int DEBOUNCE_LIMIT = 250_000
) (
   input  logic i_Clk,
   input  logic i_Rst,
   input  logic i_Switch,
   output logic o_Level,
   output logic o_Press
);

   localparam int CW = cnt_width(DEBOUNCE_LIMIT);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          filt_cnt_q;
   logic                   level_q;
   logic                   level_d_q;
   logic                   press_q;

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         sync_q     <= '0;
         filt_cnt_q <= '0;
         level_q    <= 1'b0;
         level_d_q  <= 1'b0;
         press_q    <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], i_Switch};
         level_d_q <= level_q;
         press_q   <= level_q & ~level_d_q;
         // Any cycle where the synced level agrees with the accepted one restarts the count.
         if (sync_q[SYNC_STAGES-1] != level_q) begin
            if (filt_cnt_q == CW'(DEBOUNCE_LIMIT - 1)) begin
               level_q    <= ~level_q;
               filt_cnt_q <= '0;
            end else begin
               filt_cnt_q <= filt_cnt_q + CW'(1);
            end
         end else begin
            filt_cnt_q <= '0;
         end
      end
   end

   assign o_Level = level_q;
   assign o_Press = press_q;

endmodule

// File: rtl/switch_updown_counter.sv
// Debounced switches step a 4-bit wrapping count shown on the LEDs (Switch_1 up, 2 down, 3 clear).
// Define AUTO_REPEAT_EN to add hold-to-repeat on the up/down switches.
module switch_updown_counter
   import switch_pkg::*;
#(
   parameter int DEBOUNCE_LIMIT = 250_000,
   parameter int REPEAT_DELAY   = 12_500_000,
   parameter int REPEAT_PERIOD  = 2_500_000
) (
   input  logic                    i_Clk,
   input  logic                    i_Rst,
   switch_updown_counter_if.slave  sw_if
);

   logic [2:0]         lvl;
   logic [2:0]         prs;
   logic [COUNT_W-1:0] count_q;
   logic               step_q;
   logic               rep_inc;
   logic               rep_dec;
   logic               inc_ev;
   logic               dec_ev;
   logic [2:0]         unused_lvl;

   switch_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_deb_inc (
      .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Switch(sw_if.i_Switch_1),
      .o_Level(lvl[0]), .o_Press(prs[0])
   );
   switch_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_deb_dec (
      .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Switch(sw_if.i_Switch_2),
      .o_Level(lvl[1]), .o_Press(prs[1])
   );
   switch_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_deb_clr (
      .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Switch(sw_if.i_Switch_3),
      .o_Level(lvl[2]), .o_Press(prs[2])
   );

   assign unused_lvl = lvl;

`ifdef AUTO_REPEAT_EN
   localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int TW   = cnt_width(TMAX);

   rpt_state_t state_q;
   logic       dir_up_q;
   logic [TW-1:0] timer_q;
   logic       held;
   logic       hit;
   logic       abort;
   logic       rep_tick;

   // Abort covers release, an opposite-direction press and a clear press.
   always_comb begin
      held     = dir_up_q ? lvl[0] : lvl[1];
      hit      = (state_q == ST_DELAY) ? (timer_q == TW'(REPEAT_DELAY - 1))
                                       : (timer_q == TW'(REPEAT_PERIOD - 1));
      abort    = prs[2] | (dir_up_q ? prs[1] : prs[0]) | ~held;
      rep_tick = (state_q != ST_IDLE) & ~abort & hit;
      rep_inc  = rep_tick & dir_up_q;
      rep_dec  = rep_tick & ~dir_up_q;
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q  <= ST_IDLE;
         dir_up_q <= 1'b0;
         timer_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               timer_q <= '0;
               if ((prs[0] ^ prs[1]) & ~prs[2]) begin
                  state_q  <= ST_DELAY;
                  dir_up_q <= prs[0];
               end
            end
            ST_DELAY, ST_REPEAT: begin
               if (abort) begin
                  state_q <= ST_IDLE;
                  timer_q <= '0;
               end else if (hit) begin
                  state_q <= ST_REPEAT;
                  timer_q <= '0;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               timer_q <= '0;
            end
         endcase
      end
   end

   assign sw_if.o_Rpt_State = state_q;
`else
   logic [63:0] unused_cfg;

   assign unused_cfg        = {REPEAT_DELAY, REPEAT_PERIOD};
   assign rep_inc           = 1'b0;
   assign rep_dec           = 1'b0;
   assign sw_if.o_Rpt_State = ST_IDLE;
`endif

   assign inc_ev = prs[0] | rep_inc;
   assign dec_ev = prs[1] | rep_dec;

   // Clear wins outright; opposing up/down events cancel without a step.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         count_q <= '0;
         step_q  <= 1'b0;
      end else begin
         step_q <= 1'b0;
         if (prs[2]) begin
            count_q <= '0;
            step_q  <= 1'b1;
         end else if (inc_ev & ~dec_ev) begin
            count_q <= count_q + COUNT_W'(1);
            step_q  <= 1'b1;
         end else if (dec_ev & ~inc_ev) begin
            count_q <= count_q - COUNT_W'(1);
            step_q  <= 1'b1;
         end
      end
   end

   assign sw_if.o_LED_1 = count_q[3];
   assign sw_if.o_LED_2 = count_q[2];
   assign sw_if.o_LED_3 = count_q[1];
   assign sw_if.o_LED_4 = count_q[0];
   assign sw_if.o_Step  = step_q;

endmodule
